// File: rtl/cachepool_boot_sequencer.sv
// Boot sequencer for the CachePool cluster. It waits a settle delay, writes the entry point to BOOT_CONTROL
// over reqrsp, waits for the response, and then pulses debug_req_o. Optional macro: BOOT_SEQ_TIMEOUT_EN (response timeout).
module cachepool_boot_sequencer #(
  parameter int unsigned          AddrWidth     = 48,
  parameter int unsigned          DataWidth     = 64,
  parameter int unsigned          NumCores      = 4,
  parameter logic [AddrWidth-1:0] BootCtrlAddr  = '0,
  parameter int unsigned          BootDelay     = 1000,
  parameter int unsigned          TimeoutCycles = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [31:0]            entry_point_i,
  output logic [AddrWidth-1:0]   q_addr_o,
  output logic [DataWidth-1:0]   q_data_o,
  output logic                   q_write_o,
  output logic [DataWidth/8-1:0] q_strb_o,
  output logic                   q_valid_o,
  input  logic                   q_ready_i,
  input  logic                   p_valid_i,
  input  logic                   p_error_i,
  output logic                   p_ready_o,
  output logic [NumCores-1:0]    debug_req_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   error_o
);

  // One counter serves both the settle delay and the response timeout.
  localparam int unsigned CntMax = (BootDelay > TimeoutCycles) ? BootDelay : TimeoutCycles;
  localparam int unsigned CntW   = (CntMax < 2) ? 1 : $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    StIdle,
    StDelay,
    StReq,
    StRsp,
    StWake,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     entry_q, entry_d;
  logic            error_q, error_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      entry_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      entry_q <= entry_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    entry_d     = entry_q;
    error_d     = error_q;
    q_valid_o   = 1'b0;
    q_write_o   = 1'b0;
    q_strb_o    = '0;
    q_addr_o    = '0;
    q_data_o    = '0;
    p_ready_o   = 1'b0;
    debug_req_o = '0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start_i) begin
          entry_d = entry_point_i;
          error_d = 1'b0;
          cnt_d   = CntW'(BootDelay);
          state_d = (BootDelay == 0) ? StReq : StDelay;
        end
      end
      StDelay: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CntW'(1)) state_d = StReq;
      end
      StReq: begin
        // Request fields depend only on state and the latched entry point, so they stay stable until handshake.
        q_valid_o = 1'b1;
        q_write_o = 1'b1;
        q_strb_o  = '1;
        q_addr_o  = BootCtrlAddr;
        q_data_o  = DataWidth'(entry_q);
        if (q_ready_i) begin
          state_d = StRsp;
`ifdef BOOT_SEQ_TIMEOUT_EN
          cnt_d   = CntW'(TimeoutCycles);
`endif
        end
      end
      StRsp: begin
        p_ready_o = 1'b1;
        if (p_valid_i) begin
          if (p_error_i) begin
            error_d = 1'b1;
            state_d = StDone;
          end else begin
            state_d = StWake;
          end
        end
`ifdef BOOT_SEQ_TIMEOUT_EN
        else if (cnt_q <= CntW'(1)) begin
          error_d = 1'b1;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`endif
      end
      StWake: begin
        debug_req_o = '1;
        state_d     = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_o  = (state_q == StDelay) || (state_q == StReq) ||
                   (state_q == StRsp)   || (state_q == StWake);
  assign done_o  = (state_q == StDone);
  assign error_o = error_q;

endmodule
